// File: rtl/spike_event_encoder_if.sv
// Event stream handshake between the spike event encoder and its consumer.
//   evt_data  : {spike_mask[1:0], timestamp[TS_WIDTH-1:0]} at the FIFO head
//   evt_valid : head word present
//   evt_ready : consumer takes the head word this cycle
// master = encoder (producer), slave = readout logic (consumer).
interface spike_event_encoder_if #(
  parameter int unsigned TS_WIDTH = 8
) ();

  logic [TS_WIDTH+1:0] evt_data;
  logic                evt_valid;
  logic                evt_ready;

  modport master (
    output evt_data,
    output evt_valid,
    input  evt_ready
  );

  modport slave (
    input  evt_data,
    input  evt_valid,
    output evt_ready
  );

endinterface

// File: rtl/spike_event_encoder.sv
// Timestamped spike event encoder for a pair of LIF neurons.
// Rising edges on spike_in are stamped with a free-running (enable-gated) timestamp and
// queued as {rise_mask, ts} words in a first-word-fall-through FIFO. Coincident rises on
// both lines merge into one word.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   ena            : freezes timestamp and event capture when low
//   spike_in[1:0]  : bit0 = neuron1, bit1 = neuron2
//   evt (master)   : evt_data / evt_valid / evt_ready event stream
//   overflow       : sticky, set when an event is dropped on a full FIFO
//   rate0, rate1   : per-neuron spike counts of the last completed rate window
//
// Build option: define SPIKE_RATE_EN to build the rate counters; otherwise rate0/rate1
// are tied to zero.
module spike_event_encoder #(
  parameter int unsigned TS_WIDTH    = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned RATE_WINDOW = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [1:0]            spike_in,
  spike_event_encoder_if.master evt,
  output logic                  overflow,
  output logic [7:0]            rate0,
  output logic [7:0]            rate1
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned WordW = TS_WIDTH + 2;
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (RATE_WINDOW < 1) begin : g_bad_window
    $error("RATE_WINDOW must be at least 1");
  end

  logic [TS_WIDTH-1:0] ts;
  logic [1:0]          spike_q;
  logic [1:0]          rise;
  logic                push_req;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;

  logic [WordW-1:0]    mem [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr;
  logic [PtrW-1:0]     rd_ptr;
  logic [PtrW:0]       count;

  // spike_q tracks the lines even while disabled, so a line that went high during a
  // disabled stretch is not seen as a fresh edge once ena returns.
  assign rise     = spike_in & ~spike_q;
  assign push_req = ena & (rise != 2'b00);
  assign empty    = (count == '0);
  assign full     = (count == DepthCnt);
  assign pop      = ~empty & evt.evt_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      ts      <= '0;
      spike_q <= '0;
    end else begin
      spike_q <= spike_in;
      if (ena) begin
        ts <= ts + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (push_req && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {rise, ts};
    end
  end

  assign evt.evt_valid = ~empty;
  assign evt.evt_data  = empty ? '0 : mem[rd_ptr];

`ifdef SPIKE_RATE_EN
  localparam int unsigned WinW = (RATE_WINDOW > 1) ? $clog2(RATE_WINDOW) : 1;
  localparam logic [WinW-1:0] WinLast = WinW'(RATE_WINDOW - 1);

  logic [WinW-1:0] win_q;
  logic [7:0]      cnt0_q;
  logic [7:0]      cnt1_q;
  logic [7:0]      cnt0_d;
  logic [7:0]      cnt1_d;
  logic [7:0]      rate0_q;
  logic [7:0]      rate1_q;
  logic            win_end;

  // Saturating per-neuron counts including this cycle's rises.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (ena && rise[0] && cnt0_q != 8'hFF) begin
      cnt0_d = cnt0_q + 8'd1;
    end
    if (ena && rise[1] && cnt1_q != 8'hFF) begin
      cnt1_d = cnt1_q + 8'd1;
    end
  end

  assign win_end = (win_q == WinLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      rate0_q <= '0;
      rate1_q <= '0;
    end else if (ena) begin
      if (win_end) begin
        win_q   <= '0;
        cnt0_q  <= '0;
        cnt1_q  <= '0;
        rate0_q <= cnt0_d;
        rate1_q <= cnt1_d;
      end else begin
        win_q  <= win_q + 1'b1;
        cnt0_q <= cnt0_d;
        cnt1_q <= cnt1_d;
      end
    end
  end

  assign rate0 = rate0_q;
  assign rate1 = rate1_q;
`else
  assign rate0 = '0;
  assign rate1 = '0;
`endif

endmodule

// File: tb/tb_spike_event_encoder.sv
// Bench for spike_event_encoder: a reference model at the falling edge predicts every event
// word and the overflow flag, plus a vector table and hand-written corner sequences.
module tb_spike_event_encoder;

  localparam int unsigned TsW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [1:0] spike_in;
  logic       overflow;
  logic [7:0] rate0;
  logic [7:0] rate1;

  spike_event_encoder_if #(.TS_WIDTH(TsW)) bus ();

  spike_event_encoder #(
    .TS_WIDTH   (TsW),
    .FIFO_DEPTH (4),
    .RATE_WINDOW(256)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .spike_in(spike_in),
    .evt     (bus),
    .overflow(overflow),
    .rate0   (rate0),
    .rate1   (rate1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Runs at the falling edge: compares the outputs registered at the last
  // rising edge, then advances its state as the coming rising edge will.
  logic [9:0] sb [$];
  logic [7:0] m_ts   = '0;
  logic [1:0] m_prev = '0;
  logic       m_ovf  = 1'b0;

  always @(negedge clk) begin : scoreboard
    logic [1:0] m_rise;
    logic       m_pop;
    logic       m_full;
    chk("sb_valid", 32'(bus.evt_valid), 32'(sb.size() != 0));
    chk("sb_data", 32'(bus.evt_data), (sb.size() != 0) ? 32'(sb[0]) : 32'd0);
    chk("sb_overflow", 32'(overflow), 32'(m_ovf));
    if (rst) begin
      sb.delete();
      m_ts   = '0;
      m_prev = '0;
      m_ovf  = 1'b0;
    end else begin
      m_rise = spike_in & ~m_prev;
      m_pop  = (sb.size() != 0) && bus.evt_ready;
      m_full = (sb.size() == 4);
      if (m_pop) void'(sb.pop_front());
      if (ena && m_rise != 2'b00) begin
        if (!m_full || m_pop) sb.push_back({m_rise, m_ts});
        else m_ovf = 1'b1;
      end
      if (ena) m_ts = m_ts + 8'd1;
      m_prev = spike_in;
    end
  end

  task automatic step(input logic e, input logic [1:0] s, input logic r);
    ena           = e;
    spike_in      = s;
    bus.evt_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Idle with ena=1 until the DUT timestamp equals t (bounded).
  task automatic wait_ts(input logic [7:0] t, input logic r);
    int n = 0;
    while (m_ts != t && n < 600) begin
      step(1'b1, 2'b00, r);
      n++;
    end
    chk("wait_ts", 32'(m_ts), 32'(t));
  endtask

  typedef struct {
    logic       ena;
    logic [1:0] spike;
    logic       ready;
    logic       exp_valid;
    logic [9:0] exp_data;
  } vec_t;

  vec_t       tbl [26];
  logic [7:0] ovf_ts  [5] = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd9};
  logic [7:0] full_ts [4] = '{8'd4, 8'd6, 8'd8, 8'd30};
  logic [7:0] fill_ts [4] = '{8'd2, 8'd4, 8'd6, 8'd8};
  logic [7:0] t0;
  logic [7:0] t_exp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ena = 1'b1; spike_in = 2'b00; bus.evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_valid", 32'(bus.evt_valid), 32'd0);
    chk("reset_data", 32'(bus.evt_data), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_rate0", 32'(rate0), 32'd0);
    chk("reset_rate1", 32'(rate1), 32'd0);

    // Row i takes effect at the rising edge where ts == i.
    for (int i = 0; i < 26; i++) begin
      tbl[i] = '{ena: 1'b1, spike: 2'b00, ready: 1'b0, exp_valid: 1'b0, exp_data: 10'h000};
    end
    tbl[5].spike = 2'b01; tbl[5].exp_valid = 1'b1; tbl[5].exp_data = {2'b01, 8'd5};
    tbl[6].ready = 1'b1;
    for (int i = 20; i < 24; i++) begin
      tbl[i].spike = 2'b11; tbl[i].exp_valid = 1'b1; tbl[i].exp_data = {2'b11, 8'd20};
    end
    tbl[24].ready = 1'b1;
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].ena, tbl[i].spike, tbl[i].ready);
      chk($sformatf("tbl%0d_valid", i), 32'(bus.evt_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_data", i), 32'(bus.evt_data), 32'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'd0);
    end

    // Overflow: fifth event dropped, flag sticks through the drain.
    for (int k = 0; k < 5; k++) begin
      wait_ts(ovf_ts[k], 1'b0);
      step(1'b1, 2'b01, 1'b0);
    end
    step(1'b1, 2'b00, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_drain%0d", k), 32'(bus.evt_data), 32'({2'b01, ovf_ts[k]}));
      step(1'b1, 2'b00, 1'b1);
    end
    chk("ovf_empty", 32'(bus.evt_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset with a queued event discards it and clears overflow.
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    chk("pre_rst_valid", 32'(bus.evt_valid), 32'd1);
    rst = 1'b1;
    step(1'b1, 2'b00, 1'b0);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(bus.evt_valid), 32'd0);
    chk("mid_rst_data", 32'(bus.evt_data), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);

    // Full FIFO with simultaneous push and pop: no drop, occupancy stays 4.
    for (int k = 0; k < 4; k++) begin
      wait_ts(fill_ts[k], 1'b0);
      step(1'b1, 2'b01, 1'b0);
    end
    wait_ts(8'd30, 1'b0);
    step(1'b1, 2'b01, 1'b1);
    chk("full_pp_overflow", 32'(overflow), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("full_pp_valid%0d", k), 32'(bus.evt_valid), 32'd1);
      chk($sformatf("full_pp_drain%0d", k), 32'(bus.evt_data), 32'({2'b01, full_ts[k]}));
      step(1'b1, 2'b00, 1'b1);
    end
    chk("full_pp_empty", 32'(bus.evt_valid), 32'd0);

    // Timestamp wrap: events at 255 and 0 on different lines.
    wait_ts(8'd255, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    chk("wrap_first", 32'(bus.evt_data), 32'({2'b01, 8'd255}));
    step(1'b1, 2'b00, 1'b1);
    chk("wrap_second", 32'(bus.evt_data), 32'({2'b10, 8'd0}));
    step(1'b1, 2'b00, 1'b1);
    chk("wrap_empty", 32'(bus.evt_valid), 32'd0);

    // Disable while a line rises, re-enable with it still high: no event, ts frozen.
    t0 = m_ts;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 2'b01, 1'b0);
      chk($sformatf("dis_valid%0d", k), 32'(bus.evt_valid), 32'd0);
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 2'b01, 1'b0);
      chk($sformatf("reen_valid%0d", k), 32'(bus.evt_valid), 32'd0);
    end
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    t_exp = t0 + 8'd3;
    chk("frozen_ts_valid", 32'(bus.evt_valid), 32'd1);
    chk("frozen_ts_data", 32'(bus.evt_data), 32'({2'b10, t_exp}));
    // Drain works with ena low.
    step(1'b0, 2'b00, 1'b1);
    chk("drain_disabled", 32'(bus.evt_valid), 32'd0);

`ifdef SPIKE_RATE_EN
    rst = 1'b1;
    step(1'b1, 2'b00, 1'b1);
    rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      wait_ts(8'(10 + 2 * k), 1'b1);
      step(1'b1, (k < 10) ? 2'b01 : 2'b11, 1'b1);
    end
    wait_ts(8'd0, 1'b1);
    chk("rate0_window", 32'(rate0), 32'd13);
    chk("rate1_window", 32'(rate1), 32'd3);
`else
    chk("rate0_tied", 32'(rate0), 32'd0);
    chk("rate1_tied", 32'(rate1), 32'd0);
`endif

    step(1'b1, 2'b00, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
